// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode constants and flag bit positions for the ALU slice.
//   Imported by alu_shifter and alu. The SLT/SLTU opcodes are only decoded
//   when ALU_SLT_EN is defined; their constants live here unconditionally.
package alu_pkg;

  localparam int ALU_OP_W = 5;
  typedef logic [ALU_OP_W-1:0] alu_op_t;

  localparam alu_op_t ALU_ADD  = 5'b00010;
  localparam alu_op_t ALU_SUB  = 5'b00100;
  localparam alu_op_t ALU_MUL  = 5'b00110;
  localparam alu_op_t ALU_MOD  = 5'b01000;
  localparam alu_op_t ALU_AND  = 5'b01010;
  localparam alu_op_t ALU_OR   = 5'b01011;
  localparam alu_op_t ALU_XOR  = 5'b01100;
  localparam alu_op_t ALU_SLT  = 5'b01110;
  localparam alu_op_t ALU_SLTU = 5'b01111;
  localparam alu_op_t ALU_LSTF = 5'b11100;
  localparam alu_op_t ALU_RSTF = 5'b11101;
  localparam alu_op_t ALU_ASTF = 5'b11110;

  localparam int FLAG_ZERO = 0;
  localparam int FLAG_NEG  = 1;

  // Flag value matching a zero result (used on reset).
  localparam logic [1:0] FLAG_RST = 2'b01;

endpackage

// File: rtl/alu_if.sv
// alu_if: operand/opcode/result bundle between control + datapath and the ALU.
//   alu_control : operation select
//   alu_in1/2   : operands (alu_in2 also carries the shift amount)
//   alu_result  : registered result
//   flag        : registered status, [FLAG_ZERO]=zero, [FLAG_NEG]=result MSB
//   master drives opcode/operands, slave (the ALU) drives result/flag.
interface alu_if #(
  parameter int WIDTH = 32
);
  import alu_pkg::*;

  alu_op_t            alu_control;
  logic [WIDTH-1:0]   alu_in1;
  logic [WIDTH-1:0]   alu_in2;
  logic [WIDTH-1:0]   alu_result;
  logic [1:0]         flag;

  modport master (
    output alu_control, alu_in1, alu_in2,
    input  alu_result, flag
  );

  modport slave (
    input  alu_control, alu_in1, alu_in2,
    output alu_result, flag
  );

endinterface

// File: rtl/alu_shifter.sv
// alu_shifter: combinational log-stage barrel shifter for LSTF/RSTF/ASTF.
//   data_i  : value to shift
//   shamt_i : shift amount (low log2(WIDTH) bits of operand B)
//   op_i    : ALU opcode; selects left / logical right / arithmetic right
//   data_o  : shifted value (don't-care for non-shift opcodes)
// Left shifts reuse the right-shift stages by bit-reversing in and out.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SH_W  = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [SH_W-1:0]  shamt_i,
  input  alu_op_t          op_i,
  output logic [WIDTH-1:0] data_o
);

  logic             left;
  logic             fill;
  logic [WIDTH-1:0] rev_in;
  logic [WIDTH-1:0] cur;

  always_comb begin
    left = (op_i == ALU_LSTF);
    fill = (op_i == ALU_ASTF) & data_i[WIDTH-1];
    for (int i = 0; i < WIDTH; i++) rev_in[i] = data_i[WIDTH-1-i];

    cur = left ? rev_in : data_i;
    // Stage k shifts right by 2^k; vacated MSBs take the fill bit.
    for (int k = 0; k < SH_W; k++) begin
      if (shamt_i[k])
        cur = (cur >> (1 << k)) | (fill ? ~({WIDTH{1'b1}} >> (1 << k)) : '0);
    end

    data_o = cur;
    if (left)
      for (int i = 0; i < WIDTH; i++) data_o[i] = cur[WIDTH-1-i];
  end

endmodule

// File: rtl/alu.sv
// alu: 32-bit registered ALU (one cycle latency, no enable).
//   clk   : rising-edge clock
//   reset : asynchronous active-high; forces alu_result=0, flag=01
//   bus   : alu_if.slave -- alu_control, alu_in1, alu_in2 in;
//           alu_result, flag out (both registered, no comb path from inputs)
// Optional: define ALU_SLT_EN to decode SLT (01110) and SLTU (01111);
// otherwise those codes behave like any unlisted opcode (result 0, flag 01).
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  reset,
  alu_if.slave  bus
);

  localparam int SH_W = $clog2(WIDTH);

  logic [WIDTH-1:0] a, b;
  logic [WIDTH-1:0] shift_res;
  logic [WIDTH-1:0] result_d, result_q;
  logic [1:0]       flag_d, flag_q;

  assign a = bus.alu_in1;
  assign b = bus.alu_in2;

  alu_shifter #(.WIDTH(WIDTH), .SH_W(SH_W)) u_shifter (
    .data_i  (a),
    .shamt_i (b[SH_W-1:0]),
    .op_i    (bus.alu_control),
    .data_o  (shift_res)
  );

  always_comb begin
    result_d = '0;
    case (bus.alu_control)
      ALU_ADD:  result_d = a + b;
      ALU_SUB:  result_d = a - b;
      ALU_MUL:  result_d = a * b;
      // Divide-by-zero returns the dividend (REMU semantics).
      ALU_MOD:  result_d = (b == '0) ? a : (a % b);
      ALU_AND:  result_d = a & b;
      ALU_OR:   result_d = a | b;
      ALU_XOR:  result_d = a ^ b;
      ALU_LSTF,
      ALU_RSTF,
      ALU_ASTF: result_d = shift_res;
`ifdef ALU_SLT_EN
      ALU_SLT:  result_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: result_d = {{(WIDTH-1){1'b0}}, (a < b)};
`else
`endif
      default:  result_d = '0;
    endcase

    flag_d            = '0;
    flag_d[FLAG_ZERO] = (result_d == '0);
    flag_d[FLAG_NEG]  = result_d[WIDTH-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= '0;
      flag_q   <= FLAG_RST;
    end else begin
      result_q <= result_d;
      flag_q   <= flag_d;
    end
  end

  assign bus.alu_result = result_q;
  assign bus.flag       = flag_q;

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed-vector bench for alu with hand-computed expectations.
module tb_alu;
  import alu_pkg::*;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  alu_if #(.WIDTH(32)) bus ();

  alu #(.WIDTH(32)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the next rising edge.
  task automatic vec(input string tag, input alu_op_t op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] er, input logic [1:0] ef);
    @(negedge clk);
    bus.alu_control = op;
    bus.alu_in1     = a;
    bus.alu_in2     = b;
    @(posedge clk);
    #1;
    chk({tag, ".res"}, bus.alu_result, er);
    chk({tag, ".flag"}, {30'd0, bus.flag}, {30'd0, ef});
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    bus.alu_control = ALU_ADD;
    bus.alu_in1     = 32'd3;
    bus.alu_in2     = 32'd4;

    // Reset held across clock edges with a non-zero-producing opcode.
    repeat (3) @(posedge clk);
    #1;
    chk("rst.res", bus.alu_result, 32'd0);
    chk("rst.flag", {30'd0, bus.flag}, 32'd1);

    @(negedge clk);
    reset = 1'b0;
    vec("add", ALU_ADD, 32'd15, 32'd10, 32'd25, 2'b00);
    vec("add_wrap", ALU_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 2'b01);
    vec("sub", ALU_SUB, 32'd20, 32'd5, 32'd15, 2'b00);
    vec("sub_neg", ALU_SUB, 32'd5, 32'd20, 32'hFFFF_FFF1, 2'b10);
    vec("mul", ALU_MUL, 32'd7, 32'd6, 32'd42, 2'b00);
    vec("mul_ovf", ALU_MUL, 32'h0001_0000, 32'h0001_0000, 32'd0, 2'b01);
    vec("mul_m1", ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 2'b00);
    vec("mod", ALU_MOD, 32'd25, 32'd4, 32'd1, 2'b00);
    vec("mod0", ALU_MOD, 32'd25, 32'd0, 32'd25, 2'b00);
    vec("and", ALU_AND, 32'hFF00_FF00, 32'h00FF_00FF, 32'd0, 2'b01);
    vec("or", ALU_OR, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 2'b10);
    vec("xor", ALU_XOR, 32'h1234_5678, 32'hFFFF_FFFF, 32'hEDCB_A987, 2'b10);
    vec("lstf", ALU_LSTF, 32'd25, 32'd2, 32'd100, 2'b00);
    vec("lstf_hi", ALU_LSTF, 32'd25, 32'h22, 32'd100, 2'b00);
    vec("lstf31", ALU_LSTF, 32'd1, 32'd31, 32'h8000_0000, 2'b10);
    vec("lstf0", ALU_LSTF, 32'hA5A5_0001, 32'd0, 32'hA5A5_0001, 2'b10);
    vec("rstf", ALU_RSTF, 32'd24, 32'd2, 32'd6, 2'b00);
    vec("rstf31", ALU_RSTF, 32'h8000_0000, 32'd31, 32'd1, 2'b00);
    vec("astf", ALU_ASTF, 32'h8000_0000, 32'd4, 32'hF800_0000, 2'b10);
    vec("astf_pos", ALU_ASTF, 32'h7FFF_FFF0, 32'd4, 32'h07FF_FFFF, 2'b00);
    vec("astf_hi", ALU_ASTF, 32'h8000_0000, 32'hFFFF_FFE1, 32'hC000_0000, 2'b10);
    vec("unlisted", 5'b11111, 32'd9, 32'd9, 32'd0, 2'b01);
    vec("unlisted0", 5'b00000, 32'd1, 32'd2, 32'd0, 2'b01);
`ifdef ALU_SLT_EN
    vec("slt", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 2'b00);
    vec("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 2'b01);
    vec("slt_r", ALU_SLT, 32'd1, 32'hFFFF_FFFF, 32'd0, 2'b01);
    vec("sltu_r", ALU_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd1, 2'b00);
`else
    vec("slt_off", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 2'b01);
    vec("sltu_off", ALU_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd0, 2'b01);
`endif

    // Mid-stream reset: outputs clear between edges, without a clock edge.
    vec("pre_rst", ALU_OR, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 2'b00);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst.res", bus.alu_result, 32'd0);
    chk("async_rst.flag", {30'd0, bus.flag}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    vec("post_rst", ALU_SUB, 32'd100, 32'd1, 32'd99, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
